// File: rtl/float_signed_pipe_to_linear_fixed_pkg.sv
// Shared definitions for the float -> Kulisch fixed-point converter.
//   KulischDef    : accumulator word sizing helper (getBits).
//   FloatFixedDef : rounding mode enum and the stage-1 -> stage-2 pipeline entry.
// No ports (packages only).

package KulischDef;

    // Total accumulator width: integer bits (sign included) plus fraction bits.
    function automatic int getBits(input int nonFrac, input int frac);
        return nonFrac + frac;
    endfunction

endpackage

package FloatFixedDef;

    // Exponent and fraction widths the pipeline entry is sized for.
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 8;

    typedef enum logic {
        TRUNC = 1'b0,   // arithmetic shift, rounds toward -inf
        RNE   = 1'b1    // round to nearest, ties to even
    } RoundMode_t;

    // Decoded beat handed from stage 1 to stage 2.
    // rshift is forced to 0 whenever a special/overflow/underflow flag is set,
    // so the shifter only ever sees an in-range amount.
    typedef struct packed {
        logic                    sign;
        logic                    isZero;
        logic                    isInf;
        logic                    underflow;
        logic                    expOvf;
        logic signed [EXP_W:0]   rshift;
        logic [FRAC_W:0]         mant;
    } StageEntry_t;

endpackage

// File: rtl/float_signed_pipe_to_linear_fixed_if.sv
// Bus bundle for float_signed_pipe_to_linear_fixed.
//   in_*      : upstream float beat with valid/ready handshake
//   out_*     : downstream fixed-point beat with valid/ready handshake
//   ovf_*     : sticky overflow status and its synchronous clear
// master = the side driving the float beats and consuming results; slave = the converter.

interface float_signed_pipe_to_linear_fixed_if #(
    parameter int SIGNED_EXP = 8,
    parameter int FRAC       = 8,
    parameter int TOTAL      = 20
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sign;
    logic [SIGNED_EXP-1:0] in_exp;
    logic [FRAC-1:0]       in_frac;
    logic                  in_isZero;
    logic                  in_isInf;
    logic                  out_valid;
    logic                  out_ready;
    logic [TOTAL-1:0]      out_bits;
    logic                  out_isInf;
    logic                  out_isOverflow;
    logic                  out_overflowSign;
    logic                  ovf_sticky;
    logic                  ovf_clear;

    modport master (
        output in_valid, in_sign, in_exp, in_frac, in_isZero, in_isInf, out_ready, ovf_clear,
        input  in_ready, out_valid, out_bits, out_isInf, out_isOverflow, out_overflowSign, ovf_sticky
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_frac, in_isZero, in_isInf, out_ready, ovf_clear,
        output in_ready, out_valid, out_bits, out_isInf, out_isOverflow, out_overflowSign, ovf_sticky
    );
endinterface

// File: rtl/float_signed_pipe_to_linear_fixed_round_shift.sv
// float_fixed_round_shift: combinational magnitude alignment and rounding.
//   mant     in  {1,frac}, leading one lands on the 2^(ACC_NON_FRAC-1) position before shifting
//   shAmt    in  right-shift amount (0 .. TOTAL+1)
//   sign     in  value sign, only used by the truncate-toward--inf mode
//   mag      out rounded unsigned magnitude, LSB weight 2^-ACC_FRAC
//   carryOut out magnitude reached 2^(ACC_NON_FRAC-1) (top bit of mag)

module float_fixed_round_shift
    import FloatFixedDef::*;
#(
    parameter int         FRAC    = 8,
    parameter int         TOTAL   = 20,
    parameter int         SHIFT_W = 9,
    parameter RoundMode_t MODE    = RNE
) (
    input  logic [FRAC:0]        mant,
    input  logic [SHIFT_W-1:0]   shAmt,
    input  logic                 sign,
    output logic [TOTAL-1:0]     mag,
    output logic                 carryOut
);
    // Padding below the mantissa must cover the largest shift so nothing
    // falls off the bottom; every discarded bit stays visible to sticky.
    localparam int EW  = TOTAL + FRAC;
    localparam int PAD = TOTAL + 2;
    localparam int WW  = EW + PAD;

    logic [WW-1:0]    wide;
    logic [WW-1:0]    shifted;
    logic [TOTAL-1:0] kept;
    logic             guard;
    logic             sticky;
    logic             roundUp;

    function automatic logic rneUp(input logic g, input logic s, input logic lsb);
        return g && (s || lsb);
    endfunction

    // Magnitude truncation of a negative value moves toward zero; any
    // discarded weight must bump it to reach -inf after negation.
    function automatic logic floorUp(input logic neg, input logic g, input logic s);
        return neg && (g || s);
    endfunction

    assign wide    = {mant, {(TOTAL-1){1'b0}}, {PAD{1'b0}}};
    assign shifted = wide >> shAmt;
    assign kept    = shifted[WW-1 -: TOTAL];
    assign guard   = shifted[PAD+FRAC-1];
    assign sticky  = |shifted[PAD+FRAC-2:0];
    assign roundUp = (MODE == RNE) ? rneUp(guard, sticky, kept[0]) : floorUp(sign, guard, sticky);

    assign mag      = kept + {{(TOTAL-1){1'b0}}, roundUp};
    assign carryOut = mag[TOTAL-1];
endmodule

// File: rtl/float_signed_pipe_to_linear_fixed.sv
// float_signed_pipe_to_linear_fixed: elastic 2-stage float -> two's-complement Kulisch word.
//   clock  in  rising-edge clock
//   reset  in  asynchronous, active-high; drops in-flight beats, clears outputs and sticky
//   bus    slave side of float_signed_pipe_to_linear_fixed_if (in_*, out_*, ovf_*)
// Stage 1 decodes specials and exponent range; stage 2 shifts, rounds, saturates and negates.

module float_signed_pipe_to_linear_fixed
    import FloatFixedDef::*;
#(
    parameter int SIGNED_EXP   = EXP_W,
    parameter int FRAC         = FRAC_W,
    parameter int ACC_NON_FRAC = 16,
    parameter int ACC_FRAC     = 4,
    parameter int ROUND_MODE   = 1
) (
    input  logic clock,
    input  logic reset,
    float_signed_pipe_to_linear_fixed_if.slave bus
);
    localparam int         TOTAL = KulischDef::getBits(ACC_NON_FRAC, ACC_FRAC);
    localparam int         SH_W  = SIGNED_EXP + 1;
    localparam RoundMode_t RMODE = (ROUND_MODE != 0) ? RNE : TRUNC;
    localparam logic signed [SH_W-1:0] TOP_EXP   = SH_W'(ACC_NON_FRAC - 1);
    localparam logic signed [SH_W-1:0] UFL_SHIFT = SH_W'(TOTAL + 1);

    function automatic logic [TOTAL-1:0] satValue(input logic neg);
        return neg ? {1'b1, {(TOTAL-1){1'b0}}} : {1'b0, {(TOTAL-1){1'b1}}};
    endfunction

    logic              vld_p1, vld_p2;
    logic              adv1, adv2;
    StageEntry_t       ent, ent_p1;
    logic signed [SH_W-1:0] rshift;
    logic              special, exactNegTop, expOvf, underflow;
    logic [TOTAL-1:0]  mag;
    logic              carryOut;
    logic signed [TOTAL-1:0] bitsNext;
    logic              infNext, ovfNext, ovfSignNext;
    logic [TOTAL-1:0]  bits_p2;
    logic              inf_p2, ovf_p2, ovfSign_p2, sticky;

    assign adv2 = !vld_p2 || bus.out_ready;
    assign adv1 = !vld_p1 || adv2;

    assign bus.in_ready         = adv1;
    assign bus.out_valid        = vld_p2;
    assign bus.out_bits         = bits_p2;
    assign bus.out_isInf        = inf_p2;
    assign bus.out_isOverflow   = ovf_p2;
    assign bus.out_overflowSign = ovfSign_p2;
    assign bus.ovf_sticky       = sticky;

    // ---- stage 1: decode ----
    // One extra bit keeps (ACC_NON_FRAC-1) - exp from wrapping.
    assign rshift      = TOP_EXP - $signed({bus.in_exp[SIGNED_EXP-1], bus.in_exp});
    assign special     = bus.in_isInf || bus.in_isZero;
    // -2^(ACC_NON_FRAC-1) is the single value at the top exponent that fits.
    assign exactNegTop = bus.in_sign && (bus.in_frac == '0) && (rshift == '0);
    assign expOvf      = !special && (rshift[SH_W-1] || ((rshift == '0) && !exactNegTop));
    assign underflow   = !special && (rshift > UFL_SHIFT);

    always_comb begin
        ent           = '0;
        ent.sign      = bus.in_sign;
        ent.isZero    = bus.in_isZero;
        ent.isInf     = bus.in_isInf;
        ent.underflow = underflow;
        ent.expOvf    = expOvf;
        ent.rshift    = (special || expOvf || underflow) ? '0 : rshift;
        ent.mant      = {1'b1, bus.in_frac};
    end

    always_ff @(posedge clock) begin
        if (adv1 && bus.in_valid) ent_p1 <= ent;
    end

    // ---- stage 2: align, round, saturate, negate ----
    float_fixed_round_shift #(
        .FRAC    (FRAC),
        .TOTAL   (TOTAL),
        .SHIFT_W (SH_W),
        .MODE    (RMODE)
    ) u_roundShift (
        .mant     (ent_p1.mant),
        .shAmt    ($unsigned(ent_p1.rshift)),
        .sign     (ent_p1.sign),
        .mag      (mag),
        .carryOut (carryOut)
    );

    always_comb begin
        bitsNext    = ent_p1.sign ? -$signed(mag) : $signed(mag);
        infNext     = 1'b0;
        ovfNext     = 1'b0;
        ovfSignNext = 1'b0;
        if (ent_p1.isInf) begin
            bitsNext = '0;
            infNext  = 1'b1;
        end else if (ent_p1.isZero || ent_p1.underflow) begin
            bitsNext = '0;
        end else if (ent_p1.expOvf || (carryOut && !ent_p1.sign)) begin
            // A negative carry into the top bit is exactly -2^(ACC_NON_FRAC-1).
            bitsNext    = $signed(satValue(ent_p1.sign));
            ovfNext     = 1'b1;
            ovfSignNext = ent_p1.sign;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            bits_p2    <= '0;
            inf_p2     <= 1'b0;
            ovf_p2     <= 1'b0;
            ovfSign_p2 <= 1'b0;
            sticky     <= 1'b0;
        end else begin
            if (adv1) vld_p1 <= bus.in_valid;
            if (adv2) vld_p2 <= vld_p1;
            if (adv2 && vld_p1) begin
                bits_p2    <= bitsNext;
                inf_p2     <= infNext;
                ovf_p2     <= ovfNext;
                ovfSign_p2 <= ovfSignNext;
            end
            if (bus.ovf_clear)                          sticky <= 1'b0;
            else if (vld_p2 && bus.out_ready && ovf_p2) sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_float_signed_pipe_to_linear_fixed.sv
// Directed self-checking bench for float_signed_pipe_to_linear_fixed (TOTAL=20, ACC_FRAC=4, RNE).
// Expected words are hand-computed: LSB weight 1/16, sign bit weight -2^15.

module tb_float_signed_pipe_to_linear_fixed;
    logic clock;
    logic reset;
    int   nCmp  = 0;
    int   nFail = 0;

    float_signed_pipe_to_linear_fixed_if #(.SIGNED_EXP(8), .FRAC(8), .TOTAL(20)) bus ();

    float_signed_pipe_to_linear_fixed #(
        .SIGNED_EXP   (8),
        .FRAC         (8),
        .ACC_NON_FRAC (16),
        .ACC_FRAC     (4),
        .ROUND_MODE   (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [7:0] f,
                         input logic z, input logic inf);
        bus.in_sign   = s;
        bus.in_exp    = e;
        bus.in_frac   = f;
        bus.in_isZero = z;
        bus.in_isInf  = inf;
    endtask

    // One isolated beat through an idle pipeline with out_ready held high.
    task automatic oneBeat(input string tag, input logic s, input logic [7:0] e, input logic [7:0] f,
                           input logic z, input logic inf, input logic [19:0] eBits,
                           input logic eInf, input logic eOvf, input logic eSgn);
        drive(s, e, f, z, inf);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_bits"}, 32'(bus.out_bits), 32'(eBits));
        chk({tag, "_isInf"}, 32'(bus.out_isInf), 32'(eInf));
        chk({tag, "_ovf"}, 32'(bus.out_isOverflow), 32'(eOvf));
        chk({tag, "_ovfSign"}, 32'(bus.out_overflowSign), 32'(eSgn));
        tick();
        chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [19:0] bpExp [6];
    logic [19:0] heldBits;
    logic        holdValid;
    int          tx, rx;

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.ovf_clear = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_bits", 32'(bus.out_bits), 32'd0);
        chk("rst_sticky", 32'(bus.ovf_sticky), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Ordinary values and rounding.
        oneBeat("pos1p0",  1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 20'h00010, 1'b0, 1'b0, 1'b0);
        oneBeat("neg1p5",  1'b1, 8'h00, 8'h80, 1'b0, 1'b0, 20'hFFFE8, 1'b0, 1'b0, 1'b0);
        oneBeat("pos3p25", 1'b0, 8'h01, 8'hA0, 1'b0, 1'b0, 20'h00034, 1'b0, 1'b0, 1'b0);
        oneBeat("neg0p75", 1'b1, 8'hFF, 8'h80, 1'b0, 1'b0, 20'hFFFF4, 1'b0, 1'b0, 1'b0);
        oneBeat("tieHalf", 1'b0, 8'hFB, 8'h00, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0);
        oneBeat("overHalf",1'b0, 8'hFB, 8'h01, 1'b0, 1'b0, 20'h00001, 1'b0, 1'b0, 1'b0);
        oneBeat("tieOdd",  1'b0, 8'hFC, 8'h80, 1'b0, 1'b0, 20'h00002, 1'b0, 1'b0, 1'b0);
        oneBeat("under",   1'b1, 8'hEC, 8'h55, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0);
        chk("sticky_quiet", 32'(bus.ovf_sticky), 32'd0);

        // Range limits.
        oneBeat("ovfPos",  1'b0, 8'h0F, 8'h00, 1'b0, 1'b0, 20'h7FFFF, 1'b0, 1'b1, 1'b0);
        chk("sticky_set", 32'(bus.ovf_sticky), 32'd1);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;
        chk("sticky_clr", 32'(bus.ovf_sticky), 32'd0);
        oneBeat("exactNeg",1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b0, 1'b0);
        chk("sticky_exact", 32'(bus.ovf_sticky), 32'd0);
        oneBeat("ovfNeg",  1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1, 1'b1);
        oneBeat("ovfNegTop",1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1, 1'b1);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;

        // Specials with garbage payload.
        oneBeat("inf",     1'b1, 8'h7F, 8'hFF, 1'b0, 1'b1, 20'h00000, 1'b1, 1'b0, 1'b0);
        oneBeat("zero",    1'b1, 8'h7F, 8'h3C, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0);
        oneBeat("infZero", 1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 20'h00000, 1'b1, 1'b0, 1'b0);
        chk("sticky_specials", 32'(bus.ovf_sticky), 32'd0);

        // Backpressure: 6 beats of +2^i, out_ready low during cycles 2..4.
        for (int i = 0; i < 6; i++) bpExp[i] = 20'h00010 << i;
        tx = 0;
        rx = 0;
        holdValid = 1'b0;
        heldBits  = '0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            bus.out_ready = !(c >= 2 && c <= 4);
            bus.in_valid  = (tx < 6);
            drive(1'b0, 8'(tx), 8'h00, 1'b0, 1'b0);
            #1;
            if (tx < 6) chk("bp_in_ready", 32'(bus.in_ready), 32'(!(c >= 2 && c <= 4)));
            if (bus.out_valid && holdValid) chk("bp_hold", 32'(bus.out_bits), 32'(heldBits));
            if (bus.out_valid && bus.out_ready) begin
                chk("bp_bits", 32'(bus.out_bits), 32'(bpExp[rx]));
                rx++;
                holdValid = 1'b0;
            end else if (bus.out_valid) begin
                heldBits  = bus.out_bits;
                holdValid = 1'b1;
            end
            if (bus.in_valid && bus.in_ready) tx++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_all_emitted", 32'(rx), 32'd6);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Clear wins over a same-cycle overflow handshake.
        drive(1'b0, 8'h0F, 8'h00, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("clrRace_ovf", 32'(bus.out_isOverflow), 32'd1);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;
        chk("clrRace_sticky", 32'(bus.ovf_sticky), 32'd0);

        // Asynchronous reset with two beats in flight.
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("rstFly_pre", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstFly_valid", 32'(bus.out_valid), 32'd0);
        chk("rstFly_bits", 32'(bus.out_bits), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rstFly_stale", 32'(bus.out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
